ship_life_ctrl: RTL

Game-flow controller that sequences the spaceship datapath. It consumes the ship's per-move collision flag and the frame tick, and produces the ship's `move` strobe, respawn reset, visibility enable, and lives count. It implements the idle / play / respawn / invulnerable / game-over flow. It sits between the VGA timing block and the spaceship module, and all of its registers advance only on pixpulse cycles.

---
 rtl/ship_life_if.sv | 24 ++
 rtl/ship_life_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ship_life_if.sv
// Handshake bundle between the game-flow controller and its neighbours:
// timing enables and ship flags in, ship control strobes and lives out.
interface ship_life_if;
  logic       pixpulse;
  logic       frame_tick;
  logic       collide;
  logic       start;
  logic       move;
  logic       ship_rst;
  logic       ship_visible;
  logic       invuln;
  logic       game_over;
  logic [1:0] lives;

  modport master (
    output pixpulse, frame_tick, collide, start,
    input  move, ship_rst, ship_visible, invuln, game_over, lives
  );

  modport slave (
    input  pixpulse, frame_tick, collide, start,
    output move, ship_rst, ship_visible, invuln, game_over, lives
  );
endinterface

// File: rtl/ship_life_ctrl.sv
// Game-flow controller: idle / play / respawn / invulnerable / game-over
// sequencing of the spaceship, advancing only on pixpulse cycles.
module ship_life_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_FRAMES   = 8
) (
  input logic        clk,
  input logic        rst_n,
  ship_life_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PLAY, RESPAWN, INVULN, OVER} state_t;

  localparam logic [1:0] LIVES0    = 2'(LIVES_INIT);
  localparam logic [7:0] RESP_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] INV_LAST  = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK     = 8'(BLINK_FRAMES);

  state_t     state, state_nx;
  logic [7:0] fcnt, fcnt_nx;
  logic [1:0] lives, lives_nx;
  logic       start_q, start_edge;
  logic       move, move_nx;
  logic       ship_rst, ship_rst_nx;
  logic [7:0] blink_idx;

  assign start_edge = bus.start & ~start_q;

  always_comb begin
    state_nx    = state;
    fcnt_nx     = fcnt;
    lives_nx    = lives;
    move_nx     = 1'b0;
    ship_rst_nx = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          state_nx    = PLAY;
          lives_nx    = LIVES0;
          fcnt_nx     = 8'd0;
          ship_rst_nx = 1'b1;
        end
      end
      PLAY: begin
        // collide wins over frame_tick: no move in the period of a hit
        if (bus.collide) begin
          if (lives <= 2'd1) begin
            lives_nx = 2'd0;
            state_nx = OVER;
          end else begin
            lives_nx    = lives - 2'd1;
            state_nx    = RESPAWN;
            fcnt_nx     = 8'd0;
            ship_rst_nx = 1'b1;
          end
        end else begin
          move_nx = bus.frame_tick;
        end
      end
      RESPAWN: begin
        if (bus.frame_tick) begin
          if (fcnt == RESP_LAST) begin
            state_nx = INVULN;
            fcnt_nx  = 8'd0;
          end else begin
            fcnt_nx = fcnt + 8'd1;
          end
        end
      end
      INVULN: begin
        move_nx = bus.frame_tick;
        if (bus.frame_tick) begin
          if (fcnt == INV_LAST) begin
            state_nx = PLAY;
            fcnt_nx  = 8'd0;
          end else begin
            fcnt_nx = fcnt + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fcnt     <= 8'd0;
      lives    <= LIVES0;
      start_q  <= 1'b0;
      move     <= 1'b0;
      ship_rst <= 1'b0;
    end else if (bus.pixpulse) begin
      state    <= state_nx;
      fcnt     <= fcnt_nx;
      lives    <= lives_nx;
      start_q  <= bus.start;
      move     <= move_nx;
      ship_rst <= ship_rst_nx;
    end
  end

  // blink phase: even groups of BLINK frames visible, odd groups hidden
  assign blink_idx = fcnt / BLINK;

  always_comb begin
    bus.ship_visible = 1'b1;
    case (state)
      RESPAWN, OVER: bus.ship_visible = 1'b0;
      INVULN:        bus.ship_visible = ~blink_idx[0];
      default:       bus.ship_visible = 1'b1;
    endcase
  end

  assign bus.move      = move;
  assign bus.ship_rst  = ship_rst;
  assign bus.invuln    = (state == INVULN);
  assign bus.game_over = (state == OVER);
  assign bus.lives     = lives;
endmodule
